// File: rtl/sumador_serial.sv
// Bit-serial ANCHO-bit adder: latches two operands and a carry-in, feeds one bit
// per clock (LSB first) through a single full-adder cell and reassembles the sum.
module sumador_serial #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [ANCHO-1:0] entrada1,
  input  logic [ANCHO-1:0] entrada2,
  input  logic             entAcarreo,
  output logic             ocupado,
  output logic [ANCHO-1:0] suma,
  output logic             acarreo,
  output logic             desborde,
  output logic             listo
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] SUMANDO = 2'd1;
  localparam logic [1:0] LISTO   = 2'd2;

  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

  // One-bit full-adder cell, returns {carry, sum}.
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  logic [1:0]       estado_r;
  logic [CW-1:0]    contador_r;
  logic [ANCHO-1:0] a_r;
  logic [ANCHO-1:0] b_r;
  logic             c_r;
  logic [ANCHO-2:0] parcial_r;

  logic [1:0]       celda_s;
  logic             bit_suma_s;
  logic             bit_acarreo_s;
  logic [ANCHO-1:0] parcial_sig_s;

  // Cell evaluation for the current bit and the partial sum including it.
  always_comb begin
    celda_s       = full_adder(a_r[0], b_r[0], c_r);
    bit_suma_s    = celda_s[0];
    bit_acarreo_s = celda_s[1];
    parcial_sig_s = {bit_suma_s, parcial_r};
  end

  assign ocupado = (estado_r != REPOSO);
  assign listo   = (estado_r == LISTO);

  // Control FSM, operand serialisation and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_r   <= REPOSO;
      contador_r <= '0;
      a_r        <= '0;
      b_r        <= '0;
      c_r        <= 1'b0;
      parcial_r  <= '0;
      suma       <= '0;
      acarreo    <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      case (estado_r)
        REPOSO: begin
          if (inicio) begin
            a_r        <= entrada1;
            b_r        <= entrada2;
            c_r        <= entAcarreo;
            contador_r <= '0;
            parcial_r  <= '0;
            estado_r   <= SUMANDO;
          end
        end
        SUMANDO: begin
          c_r        <= bit_acarreo_s;
          a_r        <= {1'b0, a_r[ANCHO-1:1]};
          b_r        <= {1'b0, b_r[ANCHO-1:1]};
          parcial_r  <= parcial_sig_s[ANCHO-1:1];
          contador_r <= contador_r + CW'(1);
          // On the MSB, c_r is the carry into the MSB, so its XOR with the carry-out flags overflow.
          if (contador_r == ULTIMO) begin
            suma     <= parcial_sig_s;
            acarreo  <= bit_acarreo_s;
            desborde <= c_r ^ bit_acarreo_s;
            estado_r <= LISTO;
          end
        end
        LISTO: begin
          estado_r <= REPOSO;
        end
        default: begin
          estado_r <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: doc/sumador_serial.md
Name: sumador_serial

Overview:
- Bit-serial N-bit adder built around the existing one-bit fullAdder cell (ports entrada1, entrada2, entAcarreo, suma, acarreo).
- Adds one bit per clock, LSB first, and keeps the carry in a flop between bits.
- Sits directly upstream of the fullAdder: it latches parallel operands, serialises them into the cell, then deserialises the cell's sum bits into a parallel result with a done pulse.
- Trades ANCHO cycles of latency for a single adder cell.

Parameters:
- ANCHO, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- inicio  input  1  start request; sampled only when ocupado=0
- entrada1  input  ANCHO  operand A; sampled with an accepted inicio
- entrada2  input  ANCHO  operand B; sampled with an accepted inicio
- entAcarreo  input  1  carry-in; sampled with an accepted inicio
- ocupado  output  1  high in SUMANDO and LISTO; inicio is ignored while high
- suma  output  ANCHO  registered sum of the last completed operation
- acarreo  output  1  registered carry-out of the last completed operation
- desborde  output  1  registered two's-complement overflow of the last completed operation
- listo  output  1  one-cycle pulse: the result is valid and was just updated

Behaviour:
- Reset (asynchronous, takes effect immediately while rst=1):
  - state=REPOSO.
  - Counter, operand shift registers, carry flop and partial-sum register all cleared.
  - suma=0, acarreo=0, desborde=0, listo=0, ocupado=0.
- Reset asserted mid-operation aborts the operation. No listo pulse is produced for it, and the outputs return to 0.
- States:
  - REPOSO: ocupado=0, listo=0.
    - inicio=1 at an edge → latch entrada1, entrada2 and entAcarreo into shift registers A, B and carry flop C; set contador=0; go to SUMANDO.
    - inicio=0 → remain in REPOSO.
  - SUMANDO: ocupado=1, listo=0. Each edge:
    - Feed A[0], B[0] and C to the fullAdder.
    - C ← cell carry.
    - Shift A and B right by one.
    - Shift the cell sum bit into the partial register from the MSB side.
    - contador ← contador+1.
    - On the edge where contador==ANCHO-1:
      - suma ← final partial value including this bit.
      - acarreo ← cell carry.
      - desborde ← (carry into the MSB) XOR (cell carry); record the carry into the MSB as C at that edge.
      - Go to LISTO.
  - LISTO: ocupado=1, listo=1 for exactly one cycle; next edge → REPOSO unconditionally.
- inicio while ocupado=1 (SUMANDO or LISTO) is ignored: no queuing and no effect on the result.
- Latency: if inicio is accepted at edge k, listo is high during the cycle after edge k+ANCHO, and REPOSO is re-entered at edge k+ANCHO+1.
  - Earliest next acceptance is edge k+ANCHO+2, so throughput is one result per ANCHO+2 cycles.
- suma, acarreo and desborde change only on the completion edge or on reset. They hold the previous result throughout SUMANDO and afterwards until the next completion.
- Arithmetic: {acarreo, suma} = entrada1 + entrada2 + entAcarreo, computed modulo 2^(ANCHO+1). There is no saturation.
- Input operands may change freely after acceptance; the latched copies are used.
- contador width: clog2(ANCHO) bits, sized to hold ANCHO-1.
- No combinational path from any input to any output. All outputs are registered or decoded from state only.

Test Plan:
- ANCHO=8, reset released, inicio pulse with 0x5A+0x33+0 → listo high exactly in the cycle after edge k+8; suma=0x8D, acarreo=0, desborde=1; ocupado high for 9 cycles.
- 0xFF+0x01+0 → suma=0x00, acarreo=1, desborde=0. Then 0x80+0x80+0 → suma=0x00, acarreo=1, desborde=1.
- 0xFF+0xFF+1 → suma=0xFF, acarreo=1, desborde=0. Then 0x00+0x00+1 → suma=0x01, acarreo=0, desborde=0.
- During a running 0x12+0x34, pulse inicio with 0xFF+0xFF and change entrada1/entrada2 every cycle → exactly one listo pulse, with suma=0x46 and acarreo=0.
- Assert rst at the 4th SUMANDO cycle of 0x7F+0x01 → outputs immediately 0, state REPOSO, no listo pulse. After release, 0x7F+0x01 → suma=0x80, desborde=1.
- Hold inicio high continuously with alternating 0x10+0x01 / 0x20+0x02 → results 0x11, 0x22, …; listo pulses exactly 10 cycles apart; suma holds its value between pulses.
